// File: rtl/mmio_rgb_pwm.sv
// mmio_rgb_pwm: data-bus responder driving the board LED and an RGB LED
// through three 8-bit PWM channels with period-aligned duty updates.
module mmio_rgb_pwm #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned PRESCALE  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    localparam logic [2:0] IDX_CTRL = 3'd0;
    localparam logic [2:0] IDX_DR   = 3'd1;
    localparam logic [2:0] IDX_DG   = 3'd2;
    localparam logic [2:0] IDX_DB   = 3'd3;
    localparam logic [2:0] IDX_STAT = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]  r_ctrl;
    logic [7:0]  r_duty_r;
    logic [7:0]  r_duty_g;
    logic [7:0]  r_duty_b;
    logic [7:0]  r_shadow_r;
    logic [7:0]  r_shadow_g;
    logic [7:0]  r_shadow_b;
    logic        r_pending;
    logic [15:0] r_presc;
    logic [7:0]  r_pwm_cnt;
    logic [31:0] r_read_data;
    logic        r_red;
    logic        r_green;
    logic        r_blue;

    logic        w_wr_hit;
    logic        w_wr_legal;
    logic        w_wr_ok;
    logic        w_lane0;
    logic [2:0]  w_wr_idx;
    logic [1:0]  w_wr_off;
    logic        w_we_ctrl;
    logic        w_we_dr;
    logic        w_we_dg;
    logic        w_we_db;
    logic        w_duty_wr;
    logic [1:0]  w_ctrl_nxt;
    logic [7:0]  w_dr_nxt;
    logic [7:0]  w_dg_nxt;
    logic [7:0]  w_db_nxt;

    logic        w_rd_hit;
    logic [2:0]  w_rd_idx;
    logic [1:0]  w_rd_off;
    logic [31:0] w_rword;
    logic [31:0] w_rsh;
    logic [31:0] w_rdata;

    logic        w_en;
    logic        w_step;
    logic        w_wrap;
    logic        w_en_rise;
    logic        w_reload;
    logic        w_unused;

    assign w_wr_hit = (write_address[31:5] == BASE_ADDR[31:5]);
    assign w_wr_idx = write_address[4:2];
    assign w_wr_off = write_address[1:0];

    always_comb begin
        w_wr_legal = 1'b0;
        case (funct3)
            F3_B:    w_wr_legal = 1'b1;
            F3_H:    w_wr_legal = ~w_wr_off[0];
            F3_W:    w_wr_legal = (w_wr_off == 2'b00);
            default: w_wr_legal = 1'b0;
        endcase
    end

    assign w_wr_ok   = write_mem && w_wr_hit && w_wr_legal;
    // All writable fields live in byte lane 0; upper lanes are accepted but dropped.
    assign w_lane0   = (w_wr_off == 2'b00);
    assign w_we_ctrl = w_wr_ok && (w_wr_idx == IDX_CTRL);
    assign w_we_dr   = w_wr_ok && (w_wr_idx == IDX_DR);
    assign w_we_dg   = w_wr_ok && (w_wr_idx == IDX_DG);
    assign w_we_db   = w_wr_ok && (w_wr_idx == IDX_DB);
    assign w_duty_wr = w_we_dr || w_we_dg || w_we_db;

    assign w_ctrl_nxt = (w_we_ctrl && w_lane0) ? write_data[1:0] : r_ctrl;
    assign w_dr_nxt   = (w_we_dr && w_lane0) ? write_data[7:0] : r_duty_r;
    assign w_dg_nxt   = (w_we_dg && w_lane0) ? write_data[7:0] : r_duty_g;
    assign w_db_nxt   = (w_we_db && w_lane0) ? write_data[7:0] : r_duty_b;

    assign w_rd_hit = (read_address[31:5] == BASE_ADDR[31:5]);
    assign w_rd_idx = read_address[4:2];
    assign w_rd_off = read_address[1:0];

    always_comb begin
        w_rword = '0;
        if (w_rd_hit) begin
            case (w_rd_idx)
                IDX_CTRL: w_rword = {30'd0, r_ctrl};
                IDX_DR:   w_rword = {24'd0, r_duty_r};
                IDX_DG:   w_rword = {24'd0, r_duty_g};
                IDX_DB:   w_rword = {24'd0, r_duty_b};
                IDX_STAT: w_rword = {23'd0, r_pending, r_pwm_cnt};
                default:  w_rword = '0;
            endcase
        end
    end

    assign w_rsh = w_rword >> {w_rd_off, 3'b000};

    always_comb begin
        w_rdata = '0;
        case (funct3)
            F3_B: w_rdata = {{24{w_rsh[7]}}, w_rsh[7:0]};
            F3_H: begin
                if (!w_rd_off[0]) w_rdata = {{16{w_rsh[15]}}, w_rsh[15:0]};
            end
            F3_W: begin
                if (w_rd_off == 2'b00) w_rdata = w_rword;
            end
            F3_BU: w_rdata = {24'd0, w_rsh[7:0]};
            F3_HU: begin
                if (!w_rd_off[0]) w_rdata = {16'd0, w_rsh[15:0]};
            end
            default: w_rdata = '0;
        endcase
    end

    assign w_en      = r_ctrl[0];
    assign w_step    = w_en && (r_presc == PRESC_MAX);
    assign w_wrap    = w_step && (r_pwm_cnt == 8'hFF);
    assign w_en_rise = !w_en && w_ctrl_nxt[0];
    // Shadows track the newest duty, including one written on this very edge.
    assign w_reload  = w_wrap || w_en_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl      <= '0;
            r_duty_r    <= '0;
            r_duty_g    <= '0;
            r_duty_b    <= '0;
            r_read_data <= '0;
        end else begin
            r_ctrl      <= w_ctrl_nxt;
            r_duty_r    <= w_dr_nxt;
            r_duty_g    <= w_dg_nxt;
            r_duty_b    <= w_db_nxt;
            r_read_data <= w_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else if (!w_en) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else if (w_step) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_presc   <= r_presc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_r <= '0;
            r_shadow_g <= '0;
            r_shadow_b <= '0;
            r_pending  <= 1'b0;
        end else if (w_reload) begin
            r_shadow_r <= w_dr_nxt;
            r_shadow_g <= w_dg_nxt;
            r_shadow_b <= w_db_nxt;
            r_pending  <= 1'b0;
        end else if (w_duty_wr) begin
            r_pending  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red   <= 1'b1;
            r_green <= 1'b1;
            r_blue  <= 1'b1;
        end else begin
            r_red   <= ~(w_en && (r_pwm_cnt < r_shadow_r));
            r_green <= ~(w_en && (r_pwm_cnt < r_shadow_g));
            r_blue  <= ~(w_en && (r_pwm_cnt < r_shadow_b));
        end
    end

    assign read_data = r_read_data;
    assign led       = r_ctrl[1];
    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;

    assign w_unused = ^{write_data[31:8], w_rsh[31:16]};

endmodule
